sync_fifo1: RTL and testbench



---
 rtl/sync_fifo1.sv | 112 +++++++++++
 tb/tb_sync_fifo1.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo1.sv
// sync_fifo1: single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and an optional
// first-word-fall-through output stage. All outputs are registered.
module sync_fifo1 #(
    parameter int DSIZE  = 8,
    parameter int ASIZE  = 4,
    parameter int AFULL  = (1 << ASIZE) - 2,
    parameter int AEMPTY = 1,
    parameter int FWFT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_C  = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL);
    localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wptr, rptr, count_next;
    logic [ASIZE-1:0] waddr, raddr;
    logic             wr_acc, rd_acc;
    logic             mem_we, mem_re, byp;

    // Acceptance is judged on registered flags only, so no input reaches an
    // output combinationally.
    assign wr_acc     = winc & ~wfull;
    assign rd_acc     = rinc & ~rempty;
    assign waddr      = wptr[ASIZE-1:0];
    assign raddr      = rptr[ASIZE-1:0];
    assign count_next = count + (ASIZE+1)'(wr_acc) - (ASIZE+1)'(rd_acc);

    generate
        if (FWFT != 0) begin : g_fwft
            // The output stage is valid exactly when count is non-zero, so
            // rempty doubles as "stage empty". Memory holds the words behind it.
            // When the stage frees up it refills from memory, or straight from
            // wdata if memory has nothing queued.
            logic mem_empty, stage_free;
            always_comb begin
                mem_empty  = (wptr == rptr);
                stage_free = rempty | rd_acc;
                mem_re     = stage_free & ~mem_empty;
                byp        = stage_free & mem_empty & wr_acc;
                mem_we     = wr_acc & ~byp;
            end
        end else begin : g_std
            // Standard mode: every accepted word goes through memory and a
            // read loads the output register one edge later.
            always_comb begin
                mem_re = rd_acc;
                mem_we = wr_acc;
                byp    = 1'b0;
            end
        end
    endgenerate

    // Storage array; contents are don't-care after reset, so it has no reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we)
            mem[waddr] <= wdata;
    end

    // Pointers, count, threshold flags and sticky errors update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            wfull        <= 1'b0;
            rempty       <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (mem_we) wptr <= wptr + 1'b1;
            if (mem_re) rptr <= rptr + 1'b1;
            count        <= count_next;
            wfull        <= (count_next == DEPTH_C);
            rempty       <= (count_next == '0);
            almost_full  <= (count_next >= AFULL_C);
            almost_empty <= (count_next <= AEMPTY_C);
            if (winc && wfull)  overflow  <= 1'b1;
            if (rinc && rempty) underflow <= 1'b1;
        end
    end

    // Output data register: loaded from memory on a read/refill, or from
    // wdata on an FWFT bypass; otherwise it holds.
    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (mem_re)
            rdata <= mem[raddr];
        else if (byp)
            rdata <= wdata;
    end

endmodule

// File: tb/tb_sync_fifo1.sv
// Bench for sync_fifo1: a standard-mode and an FWFT instance share the same
// stimulus. A queue model predicts occupancy and flags; read data is checked
// by a monitor against expected-response queues filled by the stimulus.
module tb_sync_fifo1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       winc = 1'b0, rinc = 1'b0;
    logic [7:0] wdata = '0;

    logic [7:0] rdata0, rdata1;
    logic       wfull0, rempty0, af0, ae0, ovf0, unf0;
    logic       wfull1, rempty1, af1, ae1, ovf1, unf1;
    logic [4:0] count0, count1;

    always #5 clk = ~clk;

    sync_fifo1 #(.DSIZE(8), .ASIZE(4), .AFULL(14), .AEMPTY(1), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(rdata0), .wfull(wfull0), .rempty(rempty0), .almost_full(af0),
        .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0));

    sync_fifo1 #(.DSIZE(8), .ASIZE(4), .AFULL(14), .AEMPTY(1), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(rdata1), .wfull(wfull1), .rempty(rempty1), .almost_full(af1),
        .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1));

    int vectors = 0, miscompares = 0;

    logic [7:0] mq[$];     // model contents, head first
    logic [7:0] exp_q[$];  // rdata expected from standard-mode reads
    logic [7:0] fq[$];     // words the FWFT stage should present, head first
    bit         m_ovf, m_unf;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model is advanced from the FIFO rules and
    // the registered outputs of both instances are checked after the edge.
    task automatic step(bit w, logic [7:0] d, bit r, bit rs = 1'b0);
        int  n;
        bit  wa, ra;
        @(negedge clk);
        winc = w; wdata = d; rinc = r; rst = rs;
        if (rs) begin
            mq.delete(); fq.delete();
            m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            n  = mq.size();
            ra = r && (n > 0);
            wa = w && (n < 16);
            if (w && !wa) m_ovf = 1'b1;
            if (r && !ra) m_unf = 1'b1;
            if (ra) exp_q.push_back(mq.pop_front());
            if (wa) begin
                mq.push_back(d);
                fq.push_back(d);
            end
        end
        @(posedge clk);
        #2;
        n = mq.size();
        chk("count0",  count0,  n);
        chk("wfull0",  wfull0,  n == 16);
        chk("rempty0", rempty0, n == 0);
        chk("afull0",  af0,     n >= 14);
        chk("aempty0", ae0,     n <= 1);
        chk("ovf0",    ovf0,    m_ovf);
        chk("unf0",    unf0,    m_unf);
        chk("count1",  count1,  n);
        chk("wfull1",  wfull1,  n == 16);
        chk("rempty1", rempty1, n == 0);
        chk("afull1",  af1,     n >= 14);
        chk("aempty1", ae1,     n <= 1);
        chk("ovf1",    ovf1,    m_ovf);
        chk("unf1",    unf1,    m_unf);
    endtask

    // Read-data monitor: pops an expected word whenever a DUT accepts a read.
    initial begin
        logic [7:0] last;
        bit         rs, seen0, seen1;
        last = '0;
        forever begin
            @(posedge clk);
            rs    = rst;
            seen0 = !rst && rinc && !rempty0;
            seen1 = !rst && rinc && !rempty1;
            #1;
            if (rs) begin
                last = '0;
                chk("rst_rdata0", rdata0, 8'h00);
            end else begin
                if (seen0) begin
                    if (exp_q.size() == 0) chk("rd_spurious0", 1, 0);
                    else begin
                        last = exp_q.pop_front();
                        chk("rdata_std", rdata0, last);
                    end
                end else begin
                    chk("rdata_hold", rdata0, last);
                end
                if (seen1 && fq.size() > 0) void'(fq.pop_front());
                if (rempty1 === 1'b0) begin
                    if (fq.size() == 0) chk("rd_spurious1", 1, 0);
                    else chk("rdata_fwft", rdata1, fq[0]);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized run.
    initial begin
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_rdata1_stage", rdata1, 8'h00);
        // fill, overflow, drain, underflow
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
        step(1, 8'hAA, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0, 1);
        // steady state at count 8 across pointer wrap
        for (int i = 0; i < 8; i++) step(1, 8'(8'h40 + i), 0);
        for (int i = 0; i < 40; i++) step(1, 8'(8'h48 + i), 1);
        // full with write+read, then empty with write+read
        for (int i = 0; i < 8; i++) step(1, 8'(8'hC0 + i), 0);
        step(1, 8'hEE, 1);
        for (int i = 0; i < 15; i++) step(0, 0, 1);
        step(1, 8'h11, 1);
        step(0, 0, 1);
        // FWFT bypass: write into empty, then pop with concurrent write
        step(0, 0, 0, 1);
        step(1, 8'h5A, 0);
        chk("fwft_direct", rdata1, 8'h5A);
        step(1, 8'h5B, 1);
        chk("fwft_refill", rdata1, 8'h5B);
        step(0, 0, 1);
        // reset mid-operation with a write pending
        for (int i = 0; i < 9; i++) step(1, 8'(8'h90 + i), 0);
        step(1, 8'h77, 0, 1);
        step(1, 8'h31, 0);
        step(0, 0, 1);
        // randomized traffic with varying write/read bias
        for (int i = 0; i < 600; i++) begin
            int wb;
            wb = (i / 100) % 3;
            step($urandom_range(0, 3) < wb + 1, 8'($urandom), $urandom_range(0, 3) < 3 - wb,
                 $urandom_range(0, 127) == 0);
        end
        for (int i = 0; i < 18; i++) step(0, 0, 1);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
